// File: rtl/ntt_result_unloader.sv
// Buffers whole NTT result beats and streams them out one coefficient per accepted transfer.
// Latency: beat captured at edge N is presented after edge N+1; no back-pressure to the source, overflow is sticky.
module ntt_result_unloader #(
    parameter int LOG_CORE_COUNT = 4,
    parameter int COEFF_WIDTH    = 30,
    parameter int DEPTH_LOG      = 5,
    parameter int FRAME_BEATS    = 32
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            output_active,
    input  logic [(4<<LOG_CORE_COUNT)*COEFF_WIDTH-1:0]      out_flat,
    input  logic [8:0]                                      address_out,
    output logic                                            m_valid,
    input  logic                                            m_ready,
    output logic [COEFF_WIDTH-1:0]                          m_data,
    output logic [8:0]                                      m_beat_addr,
    output logic [10:0]                                     m_index,
    output logic                                            m_last,
    output logic                                            overflow,
    output logic [DEPTH_LOG:0]                              beats_pending
);

    localparam int CPB    = 4 << LOG_CORE_COUNT;
    localparam int BEAT_W = CPB * COEFF_WIDTH;
    localparam int DEPTH  = 1 << DEPTH_LOG;
    localparam int K_W    = $clog2(CPB);
    localparam int B_W    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [B_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                 overflow_q, overflow_d;

    logic [BEAT_W-1:0]    beat_mem_q [DEPTH];
    logic [8:0]           addr_mem_q [DEPTH];

    logic                 full;
    logic                 xfer;
    logic                 k_last;
    logic                 pop;
    logic                 wr;
    logic [BEAT_W-1:0]    head_dat;

    assign full     = (count_q == (DEPTH_LOG+1)'(DEPTH));
    assign m_valid  = (state_q == DRAIN);
    assign xfer     = m_valid && m_ready;
    assign k_last   = (k_q == K_W'(CPB - 1));
    assign pop      = xfer && k_last;
    // A pop frees the head slot at the same edge, so a full FIFO can still take a beat.
    assign wr       = output_active && (!full || pop);
    assign head_dat = beat_mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        k_d        = k_q;
        beat_cnt_d = beat_cnt_q;
        overflow_d = overflow_q;

        if (wr) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
        end
        if (output_active && full && !pop) begin
            overflow_d = 1'b1;
        end

        if (xfer) begin
            k_d = k_last ? '0 : k_q + K_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + DEPTH_LOG'(1);
            beat_cnt_d = (beat_cnt_q == B_W'(FRAME_BEATS - 1)) ? '0 : beat_cnt_q + B_W'(1);
        end

        case ({wr, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && count_q == (DEPTH_LOG+1)'(1) && !wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            k_q        <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            k_q        <= k_d;
            beat_cnt_q <= beat_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: nothing is read from it unless the count says it was written.
    always_ff @(posedge clk) begin
        if (rst_n && wr) begin
            beat_mem_q[wr_ptr_q] <= out_flat;
            addr_mem_q[wr_ptr_q] <= address_out;
        end
    end

    assign m_data        = m_valid ? head_dat[int'(k_q)*COEFF_WIDTH +: COEFF_WIDTH] : '0;
    assign m_beat_addr   = m_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign m_index       = 11'(beat_cnt_q) * 11'(CPB) + 11'(k_q);
    assign m_last        = m_valid && k_last && (beat_cnt_q == B_W'(FRAME_BEATS - 1));
    assign overflow      = overflow_q;
    assign beats_pending = count_q;

endmodule
